// File: rtl/anonymizer_pkg.sv
// Shared types and helpers for the anonymizer window controller.
// Holds the FSM state encoding and the window-length clamp.
package anonymizer_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_FILL  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } win_state_e;

   localparam int unsigned CLEAR_CYCLES = 2;

   // A requested length of 0 or one beyond the address space selects a full window.
   function automatic logic [31:0] clamp_win_len(input logic [31:0] req, input int unsigned addr_w);
      logic [31:0] lim;
      lim = 32'(1) << addr_w;
      if ((req == 32'd0) || (req > lim)) begin
         return lim;
      end
      return req;
   endfunction

endpackage

// File: rtl/anon_out_fifo.sv
// Two-entry output buffer between anonymizer read data and the output handshake.
// Head entry stays stable until popped.
module anon_out_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_valid,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/anonymizer_window_ctrl.sv
// Window controller: clears the anonymizer, streams one window of tuples in,
// waits for completion (with watchdog) and drains the results in address order.
module anonymizer_window_ctrl
   import anonymizer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned Q_ID_WIDTH      = 32,
   parameter int unsigned Q_ID_MASK_WIDTH = 6,
   parameter int unsigned S_ATTR_WIDTH    = 512,
   parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_WIDTH:0]        window_size,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [Q_ID_WIDTH-1:0]      q_id_in,
   input  logic [S_ATTR_WIDTH-1:0]    s_attr_in,
   output logic                       anon_rst,
   output logic                       anon_write_enable,
   output logic [Q_ID_WIDTH-1:0]      anon_q_id,
   output logic [S_ATTR_WIDTH-1:0]    anon_s_attr,
   output logic [ADDR_WIDTH-1:0]      anon_read_address,
   input  logic [Q_ID_WIDTH-1:0]      anon_q_id_out,
   input  logic [Q_ID_MASK_WIDTH-1:0] anon_q_id_mask_out,
   input  logic [S_ATTR_WIDTH-1:0]    anon_s_attr_out,
   input  logic                       anon_all_finished,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [Q_ID_WIDTH-1:0]      q_id_out,
   output logic [Q_ID_MASK_WIDTH-1:0] q_id_mask_out,
   output logic [S_ATTR_WIDTH-1:0]    s_attr_out,
   output logic                       out_last,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
   localparam int unsigned WAIT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned FIFO_W   = Q_ID_WIDTH + Q_ID_MASK_WIDTH + S_ATTR_WIDTH + 1;

   win_state_e        r_state, w_state_nxt;
   logic              r_clr_cnt, w_clr_cnt_nxt;
   logic [CNT_W-1:0]  r_win_len, w_win_len_nxt;
   logic [CNT_W-1:0]  r_fill_cnt, w_fill_cnt_nxt;
   logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic [CNT_W-1:0]  r_rd_addr, w_rd_addr_nxt;
   logic              r_infl, w_infl_nxt;
   logic              r_infl_last, w_infl_last_nxt;
   logic              r_timeout_err, w_timeout_err_nxt;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_rd_issue;
   logic [2:0]        w_occ;
   logic [1:0]        w_fifo_cnt;
   logic              w_fifo_valid;
   logic [FIFO_W-1:0] w_head;

   assign w_in_fire  = (r_state == ST_FILL) && in_valid;
   assign w_out_fire = w_fifo_valid && out_ready;

   // Occupancy counts a same-cycle pop as freed, so the slot is free when the data lands.
   assign w_occ      = 3'(w_fifo_cnt) + 3'(r_infl) - 3'(w_out_fire);
   assign w_rd_issue = (r_state == ST_DRAIN) && (r_rd_addr < r_win_len) && (w_occ < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_CLEAR;
         r_clr_cnt     <= 1'b0;
         r_win_len     <= '0;
         r_fill_cnt    <= '0;
         r_wait_cnt    <= '0;
         r_rd_addr     <= '0;
         r_infl        <= 1'b0;
         r_infl_last   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_clr_cnt     <= w_clr_cnt_nxt;
         r_win_len     <= w_win_len_nxt;
         r_fill_cnt    <= w_fill_cnt_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_rd_addr     <= w_rd_addr_nxt;
         r_infl        <= w_infl_nxt;
         r_infl_last   <= w_infl_last_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_clr_cnt_nxt     = r_clr_cnt;
      w_win_len_nxt     = r_win_len;
      w_fill_cnt_nxt    = r_fill_cnt;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_rd_addr_nxt     = r_rd_addr;
      w_timeout_err_nxt = r_timeout_err;
      w_infl_nxt        = w_rd_issue;
      w_infl_last_nxt   = w_rd_issue && (r_rd_addr == (r_win_len - CNT_W'(1)));

      case (r_state)
         ST_CLEAR: begin
            w_fill_cnt_nxt = '0;
            w_wait_cnt_nxt = '0;
            w_rd_addr_nxt  = '0;
            if (r_clr_cnt == 1'(CLEAR_CYCLES - 1)) begin
               w_clr_cnt_nxt = 1'b0;
               w_win_len_nxt = CNT_W'(clamp_win_len(32'(window_size), ADDR_WIDTH));
               w_state_nxt   = ST_FILL;
            end else begin
               w_clr_cnt_nxt = 1'b1;
            end
         end
         ST_FILL: begin
            if (w_in_fire) begin
               w_fill_cnt_nxt = r_fill_cnt + CNT_W'(1);
               if ((r_fill_cnt + CNT_W'(1)) == r_win_len) begin
                  w_fill_cnt_nxt = '0;
                  w_wait_cnt_nxt = '0;
                  w_state_nxt    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (anon_all_finished) begin
               w_state_nxt = ST_DRAIN;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout_err_nxt = 1'b1;
               w_clr_cnt_nxt     = 1'b0;
               w_state_nxt       = ST_CLEAR;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (w_rd_issue) begin
               w_rd_addr_nxt = r_rd_addr + CNT_W'(1);
            end
            if (w_out_fire && w_head[0]) begin
               w_clr_cnt_nxt = 1'b0;
               w_state_nxt   = ST_CLEAR;
            end
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   // Read data arrives one cycle after its address; r_infl marks that cycle.
   anon_out_fifo #(
      .WIDTH (FIFO_W)
   ) u_out_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_infl),
      .i_push_data ({anon_q_id_out, anon_q_id_mask_out, anon_s_attr_out, r_infl_last}),
      .i_pop       (out_ready),
      .o_head      (w_head),
      .o_valid     (w_fifo_valid),
      .o_count     (w_fifo_cnt)
   );

   assign in_ready          = (r_state == ST_FILL);
   assign anon_write_enable = w_in_fire;
   assign anon_q_id         = q_id_in;
   assign anon_s_attr       = s_attr_in;
   assign anon_rst          = (r_state == ST_CLEAR);
   assign anon_read_address = r_rd_addr[ADDR_WIDTH-1:0];
   assign out_valid         = w_fifo_valid;
   assign q_id_out          = w_head[FIFO_W-1 -: Q_ID_WIDTH];
   assign q_id_mask_out     = w_head[S_ATTR_WIDTH+1 +: Q_ID_MASK_WIDTH];
   assign s_attr_out        = w_head[1 +: S_ATTR_WIDTH];
   assign out_last          = w_head[0] && w_fifo_valid;
   assign busy              = (r_state != ST_FILL) || (r_fill_cnt != '0);
   assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_anonymizer_window_ctrl.sv
// Bench for anonymizer_window_ctrl: anonymizer stub, scoreboard of expected
// output tuples per window, and directed scenarios with literal checkpoints.
module tb_anonymizer_window_ctrl;

   localparam int unsigned AW = 8;
   localparam int unsigned QW = 32;
   localparam int unsigned MW = 6;
   localparam int unsigned SW = 512;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   window_size;
   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] q_id_in;
   logic [SW-1:0] s_attr_in;
   logic          anon_rst;
   logic          anon_write_enable;
   logic [QW-1:0] anon_q_id;
   logic [SW-1:0] anon_s_attr;
   logic [AW-1:0] anon_read_address;
   logic [QW-1:0] anon_q_id_out;
   logic [MW-1:0] anon_q_id_mask_out;
   logic [SW-1:0] anon_s_attr_out;
   logic          anon_all_finished;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] q_id_out;
   logic [MW-1:0] q_id_mask_out;
   logic [SW-1:0] s_attr_out;
   logic          out_last;
   logic          busy;
   logic          timeout_err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [QW-1:0] q;
      logic [MW-1:0] m;
      logic [SW-1:0] s;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   pop_cnt    = 0;
   int   first_fire = -1;
   int   last_fire  = -1;

   anonymizer_window_ctrl #(
      .ADDR_WIDTH      (AW),
      .Q_ID_WIDTH      (QW),
      .Q_ID_MASK_WIDTH (MW),
      .S_ATTR_WIDTH    (SW),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .window_size        (window_size),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .q_id_in            (q_id_in),
      .s_attr_in          (s_attr_in),
      .anon_rst           (anon_rst),
      .anon_write_enable  (anon_write_enable),
      .anon_q_id          (anon_q_id),
      .anon_s_attr        (anon_s_attr),
      .anon_read_address  (anon_read_address),
      .anon_q_id_out      (anon_q_id_out),
      .anon_q_id_mask_out (anon_q_id_mask_out),
      .anon_s_attr_out    (anon_s_attr_out),
      .anon_all_finished  (anon_all_finished),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .q_id_out           (q_id_out),
      .q_id_mask_out      (q_id_mask_out),
      .s_attr_out         (s_attr_out),
      .out_last           (out_last),
      .busy               (busy),
      .timeout_err        (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Anonymizer stub: stores tuples in write order, returns a fixed transform one cycle after the address.
   logic [QW-1:0] mem_q [256];
   logic [SW-1:0] mem_s [256];
   logic [AW:0]   widx;

   always @(posedge clk) begin
      if (anon_rst) begin
         widx <= '0;
      end else if (anon_write_enable) begin
         mem_q[widx[AW-1:0]] <= anon_q_id;
         mem_s[widx[AW-1:0]] <= anon_s_attr;
         widx                <= widx + 1'b1;
      end
      anon_q_id_out      <= mem_q[anon_read_address] ^ 32'hA5A5_0000;
      anon_q_id_mask_out <= mem_q[anon_read_address][MW-1:0];
      anon_s_attr_out    <= ~mem_s[anon_read_address];
   end

   task automatic chk(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic [QW-1:0] gen_q(input int k);
      return 32'h13 + 32'(k) * 32'h0001_0101;
   endfunction

   function automatic logic [SW-1:0] gen_s(input logic [QW-1:0] q);
      return {16{q ^ 32'h5A5A_5A5A}};
   endfunction

   // Scoreboard: every visible output tuple must be the next expected one; stalled outputs must hold.
   logic          prev_stall = 1'b0;
   logic [QW-1:0] prev_q;
   logic [MW-1:0] prev_m;
   logic [SW-1:0] prev_s;
   logic          prev_l;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 512'(out_valid), 512'(1));
            chk("stall_q", 512'(q_id_out), 512'(prev_q));
            chk("stall_s", s_attr_out, prev_s);
            chk("stall_last", 512'(out_last), 512'(prev_l));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 512'(out_valid), 512'(0));
            end else begin
               chk("out_q", 512'(q_id_out), 512'(exp_q[0].q));
               chk("out_mask", 512'(q_id_mask_out), 512'(exp_q[0].m));
               chk("out_s", s_attr_out, exp_q[0].s);
               chk("out_last", 512'(out_last), 512'(exp_q[0].last));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  pop_cnt++;
                  if (first_fire < 0) first_fire = cyc;
                  last_fire = cyc;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_q = q_id_out;
         prev_m = q_id_mask_out;
         prev_s = s_attr_out;
         prev_l = out_last;
      end
   end

   task automatic wait_fill();
      int g = 0;
      while (!in_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      if (!in_ready) chk("fill_timeout", 512'(in_ready), 512'(1));
   endtask

   task automatic send_win(input int n, input int base);
      int i = 0;
      int g = 0;
      exp_t e;
      while (i < n && g < 2000) begin
         q_id_in   = gen_q(base + i);
         s_attr_in = gen_s(q_id_in);
         in_valid  = 1'b1;
         #1;
         if (in_ready) begin
            chk("wr_en", 512'(anon_write_enable), 512'(1));
            chk("wr_q", 512'(anon_q_id), 512'(q_id_in));
            e.q    = q_id_in ^ 32'hA5A5_0000;
            e.m    = q_id_in[MW-1:0];
            e.s    = ~s_attr_in;
            e.last = (i == n - 1);
            exp_q.push_back(e);
            i++;
         end
         @(posedge clk); #1;
         g++;
      end
      in_valid = 1'b0;
      if (i < n) chk("send_timeout", 512'(i), 512'(n));
   endtask

   task automatic pulse_fin();
      @(posedge clk); #1;
      anon_all_finished = 1'b1;
      @(posedge clk); #1;
      anon_all_finished = 1'b0;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      chk("drain_left", 512'(exp_q.size()), 512'(0));
   endtask

   initial begin
      rst_n             = 1'b0;
      window_size       = 9'd4;
      in_valid          = 1'b0;
      q_id_in           = '0;
      s_attr_in         = '0;
      anon_all_finished = 1'b0;
      out_ready         = 1'b1;

      // Reset values and the two-cycle clear
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 512'(in_ready), 512'(0));
      chk("rst_out_valid", 512'(out_valid), 512'(0));
      chk("rst_out_last", 512'(out_last), 512'(0));
      chk("rst_wr_en", 512'(anon_write_enable), 512'(0));
      chk("rst_rd_addr", 512'(anon_read_address), 512'(0));
      chk("rst_anon_rst", 512'(anon_rst), 512'(1));
      chk("rst_timeout", 512'(timeout_err), 512'(0));
      chk("rst_busy", 512'(busy), 512'(1));
      rst_n = 1'b1;
      chk("clr0_anon_rst", 512'(anon_rst), 512'(1));
      @(posedge clk); #1;
      chk("clr1_anon_rst", 512'(anon_rst), 512'(1));
      chk("clr1_in_ready", 512'(in_ready), 512'(0));
      @(posedge clk); #1;
      chk("fill_anon_rst", 512'(anon_rst), 512'(0));
      chk("fill_in_ready", 512'(in_ready), 512'(1));
      chk("fill_busy_idle", 512'(busy), 512'(0));

      // Window of 4, finished 10 cycles after the last write, full-rate drain
      send_win(4, 0);
      chk("wait_in_ready", 512'(in_ready), 512'(0));
      chk("wait_busy", 512'(busy), 512'(1));
      repeat (10) @(posedge clk);
      #1;
      anon_all_finished = 1'b1;
      first_fire = -1;
      pop_cnt    = 0;
      @(posedge clk); #1;
      anon_all_finished = 1'b0;
      chk("a_lat0_valid", 512'(out_valid), 512'(0));
      @(posedge clk); #1;
      chk("a_lat1_valid", 512'(out_valid), 512'(0));
      @(posedge clk); #1;
      chk("a_first_valid", 512'(out_valid), 512'(1));
      chk("a_first_q", 512'(q_id_out), 512'(32'hA5A5_0013));
      chk("a_first_mask", 512'(q_id_mask_out), 512'(6'h13));
      chk("a_first_s", s_attr_out, {16{32'hA5A5_A5B6}});
      chk("a_first_last", 512'(out_last), 512'(0));
      wait_drain();
      chk("a_count", 512'(pop_cnt), 512'(4));
      chk("a_back_to_back", 512'(last_fire - first_fire), 512'(3));

      // Window size 0 selects 256; a change during FILL is ignored
      window_size = 9'd0;
      wait_fill();
      window_size = 9'd3;
      pop_cnt = 0;
      send_win(256, 100);
      chk("b_in_ready_drop", 512'(in_ready), 512'(0));
      window_size = 9'd8;
      pulse_fin();
      wait_drain();
      chk("b_count", 512'(pop_cnt), 512'(256));

      // Window of 8 with out_ready toggling every cycle
      wait_fill();
      pop_cnt = 0;
      send_win(8, 400);
      pulse_fin();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
         out_ready = ~out_ready;
         chk("c_outstanding_le2", 512'((int'(anon_read_address) - pop_cnt) <= 2), 512'(1));
      end
      out_ready = 1'b1;
      chk("c_drain_left", 512'(exp_q.size()), 512'(0));
      chk("c_count", 512'(pop_cnt), 512'(8));

      // anon_all_finished held through FILL: no early exit, WAIT lasts one cycle
      window_size = 9'd4;
      wait_fill();
      anon_all_finished = 1'b1;
      pop_cnt = 0;
      send_win(4, 600);
      chk("f_in_ready", 512'(in_ready), 512'(0));
      chk("f_wait_valid", 512'(out_valid), 512'(0));
      @(posedge clk); #1;
      anon_all_finished = 1'b0;
      chk("f_d0_valid", 512'(out_valid), 512'(0));
      @(posedge clk); #1;
      chk("f_d1_valid", 512'(out_valid), 512'(0));
      @(posedge clk); #1;
      chk("f_d2_valid", 512'(out_valid), 512'(1));
      wait_drain();
      chk("f_count", 512'(pop_cnt), 512'(4));

      // Watchdog: 16 WAIT cycles without completion
      wait_fill();
      send_win(4, 700);
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1;
         if (k < 16) chk("d_err_early", 512'(timeout_err), 512'(0));
         if (k == 16) begin
            chk("d_err_set", 512'(timeout_err), 512'(1));
            chk("d_clr0", 512'(anon_rst), 512'(1));
            exp_q.delete();
         end
         if (k == 17) begin
            chk("d_clr1", 512'(anon_rst), 512'(1));
            chk("d_clr1_ready", 512'(in_ready), 512'(0));
         end
         if (k == 18) begin
            chk("d_fill_rst", 512'(anon_rst), 512'(0));
            chk("d_fill_ready", 512'(in_ready), 512'(1));
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("d_err_sticky", 512'(timeout_err), 512'(1));

      // Asynchronous reset after 2 of 4 writes, then a clean window
      send_win(2, 800);
      chk("e_busy_pre", 512'(busy), 512'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("e_rst_in_ready", 512'(in_ready), 512'(0));
      chk("e_rst_anon_rst", 512'(anon_rst), 512'(1));
      chk("e_rst_busy", 512'(busy), 512'(1));
      chk("e_rst_err", 512'(timeout_err), 512'(0));
      chk("e_rst_valid", 512'(out_valid), 512'(0));
      chk("e_rst_addr", 512'(anon_read_address), 512'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("e_clr0", 512'(anon_rst), 512'(1));
      @(posedge clk); #1;
      chk("e_clr1", 512'(anon_rst), 512'(1));
      wait_fill();
      pop_cnt = 0;
      send_win(4, 900);
      pulse_fin();
      wait_drain();
      chk("e_count", 512'(pop_cnt), 512'(4));
      chk("e_err_clear", 512'(timeout_err), 512'(0));

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
